// File: rtl/sr_flop_bank_if.sv
// Control/status bundle for sr_flop_bank: set/reset requests, enable and
// conflict clear towards the bank; channel state, edge pulses and conflict
// status back from it.
interface sr_flop_bank_if #(
   parameter int N     = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic [N-1:0]     s;
   logic [N-1:0]     r;
   logic             clr_conflict;
   logic [N-1:0]     q;
   logic [N-1:0]     q_rise;
   logic [N-1:0]     q_fall;
   logic [N-1:0]     conflict;
   logic [CNT_W-1:0] conflict_cnt;

   modport master (
      output en, s, r, clr_conflict,
      input  q, q_rise, q_fall, conflict, conflict_cnt
   );

   modport slave (
      input  en, s, r, clr_conflict,
      output q, q_rise, q_fall, conflict, conflict_cnt
   );
endinterface

// File: rtl/sr_flop_bank.sv
// Bank of N edge-triggered set/reset flops with a compile-time policy for
// simultaneous set and reset, registered rise/fall pulses per channel,
// sticky per-channel conflict flags and a saturating conflict-cycle counter.
module sr_flop_bank #(
   parameter int N       = 4,
   parameter int MODE    = 0,
   parameter int RESET_Q = 0,
   parameter int CNT_W   = 8
) (
   input logic           clk,
   input logic           reset,
   sr_flop_bank_if.slave io_bus
);

   localparam logic [N-1:0] Q_INIT = (RESET_Q != 0) ? {N{1'b1}} : {N{1'b0}};

   logic [N-1:0]     r_q;
   logic [N-1:0]     r_s_prev;
   logic [N-1:0]     r_r_prev;
   logic [N-1:0]     r_rise;
   logic [N-1:0]     r_fall;
   logic [N-1:0]     r_conf;
   logic [CNT_W-1:0] r_cnt;

   logic [N-1:0]     w_q_nxt;
   logic [N-1:0]     w_both;
   logic [N-1:0]     w_conf_nxt;
   logic             w_any;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Next value of one channel; MODE only matters when s and r are both high.
   // Last-wins looks at the previous enabled sample to decide which request
   // arrived later; if both rose together or both were already high, hold.
   function automatic logic f_resolve(input logic q, input logic s, input logic r,
                                      input logic sp, input logic rp);
      logic nq;
      nq = q;
      if (s && !r) begin
         nq = 1'b1;
      end else if (!s && r) begin
         nq = 1'b0;
      end else if (s && r) begin
         case (MODE)
            1: nq = 1'b1;
            2: nq = 1'b0;
            3: nq = ~q;
            4: begin
               if (sp && !rp) begin
                  nq = 1'b0;
               end else if (!sp && rp) begin
                  nq = 1'b1;
               end
            end
            default: nq = q;
         endcase
      end
      return nq;
   endfunction

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Per-channel next state, conflict detection and next conflict status.
   always_comb begin
      w_q_nxt = r_q;
      for (int i = 0; i < N; i++) begin
         w_q_nxt[i] = f_resolve(r_q[i], io_bus.s[i], io_bus.r[i], r_s_prev[i], r_r_prev[i]);
      end
      w_both = io_bus.en ? (io_bus.s & io_bus.r) : '0;
      w_any  = |w_both;
      // A fresh conflict in the clearing cycle survives the clear.
      w_conf_nxt = (io_bus.clr_conflict ? '0 : r_conf) | w_both;
      w_cnt_nxt  = r_cnt;
      if (io_bus.clr_conflict) begin
         w_cnt_nxt = w_any ? CNT_W'(1) : '0;
      end else if (w_any) begin
         w_cnt_nxt = f_sat_inc(r_cnt);
      end
   end

   // Channel state, request history and edge pulses; pulses drop when disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q      <= Q_INIT;
         r_s_prev <= '0;
         r_r_prev <= '0;
         r_rise   <= '0;
         r_fall   <= '0;
      end else if (io_bus.en) begin
         r_q      <= w_q_nxt;
         r_s_prev <= io_bus.s;
         r_r_prev <= io_bus.r;
         r_rise   <= w_q_nxt & ~r_q;
         r_fall   <= ~w_q_nxt & r_q;
      end else begin
         r_rise   <= '0;
         r_fall   <= '0;
      end
   end

   // Sticky conflict flags; the clear works whether or not the bank is enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_conf <= '0;
      end else begin
         r_conf <= w_conf_nxt;
      end
   end

   // Saturating count of enabled cycles that carried at least one conflict.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

   assign io_bus.q            = r_q;
   assign io_bus.q_rise       = r_rise;
   assign io_bus.q_fall       = r_fall;
   assign io_bus.conflict     = r_conf;
   assign io_bus.conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Bench for sr_flop_bank: eight instances share one stimulus stream.
//   0..4 : MODE 0..4, RESET_Q=0, CNT_W=8
//   5    : MODE 0, CNT_W=2
//   6    : MODE 0, RESET_Q=1
//   7    : MODE 7 (undefined, behaves as hold)
module tb_sr_flop_bank;
   logic       clk;
   logic       reset;
   logic       t_en;
   logic       t_clr;
   logic [3:0] t_s;
   logic [3:0] t_r;

   logic [3:0] o_q    [8];
   logic [3:0] o_rise [8];
   logic [3:0] o_fall [8];
   logic [3:0] o_conf [8];
   logic [7:0] o_cnt  [8];

   int total;
   int bad;

   typedef struct {
      logic       rst;
      logic       en;
      logic [3:0] s;
      logic [3:0] r;
      logic       clr;
      int         dut;
      logic [3:0] q;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] conf;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 8; g++) begin : g_dut
      localparam int MD = (g < 5) ? g : ((g == 7) ? 7 : 0);
      localparam int CW = (g == 5) ? 2 : 8;
      localparam int RQ = (g == 6) ? 1 : 0;
      sr_flop_bank_if #(.N(4), .CNT_W(CW)) bus ();
      assign bus.en           = t_en;
      assign bus.s            = t_s;
      assign bus.r            = t_r;
      assign bus.clr_conflict = t_clr;
      sr_flop_bank #(.N(4), .MODE(MD), .RESET_Q(RQ), .CNT_W(CW)) u_dut (
         .clk    (clk),
         .reset  (reset),
         .io_bus (bus)
      );
      assign o_q[g]    = bus.q;
      assign o_rise[g] = bus.q_rise;
      assign o_fall[g] = bus.q_fall;
      assign o_conf[g] = bus.conflict;
      assign o_cnt[g]  = 8'(bus.conflict_cnt);
   end

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic chk(input string tag, input int d, input logic [3:0] q,
                      input logic [3:0] rise, input logic [3:0] fall,
                      input logic [3:0] conf, input logic [7:0] cnt);
      cmp($sformatf("%s.d%0d.q", tag, d),    {4'b0, o_q[d]},    {4'b0, q});
      cmp($sformatf("%s.d%0d.rise", tag, d), {4'b0, o_rise[d]}, {4'b0, rise});
      cmp($sformatf("%s.d%0d.fall", tag, d), {4'b0, o_fall[d]}, {4'b0, fall});
      cmp($sformatf("%s.d%0d.conf", tag, d), {4'b0, o_conf[d]}, {4'b0, conf});
      cmp($sformatf("%s.d%0d.cnt", tag, d),  o_cnt[d],           cnt);
   endtask

   task automatic step(input logic en, input logic [3:0] s, input logic [3:0] r, input logic clr);
      t_en  = en;
      t_s   = s;
      t_r   = r;
      t_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic v(input logic rst, input logic en, input logic [3:0] s, input logic [3:0] r,
                    input logic clr, input int d, input logic [3:0] q, input logic [3:0] rise,
                    input logic [3:0] fall, input logic [3:0] conf, input logic [7:0] cnt);
      vec_t e;
      e.rst = rst; e.en = en; e.s = s; e.r = r; e.clr = clr; e.dut = d;
      e.q = q; e.rise = rise; e.fall = fall; e.conf = conf; e.cnt = cnt;
      vecs.push_back(e);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      t_en  = 1'b0;
      t_clr = 1'b0;
      t_s   = 4'b0000;
      t_r   = 4'b0000;

      // basic set / clear (MODE 0)
      v(1, 1, 4'b0101, 4'b0000, 0, 0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 8'd0);
      v(0, 1, 4'b0000, 4'b0001, 0, 0, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 8'd0);
      v(0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      v(0, 1, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      // MODE 0: hold
      v(1, 1, 4'b0001, 4'b0001, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0001, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'd2);
      // MODE 1: set-dominant
      v(1, 1, 4'b0001, 4'b0001, 0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0000, 0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0001, 0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'd2);
      // MODE 2: reset-dominant
      v(1, 1, 4'b0001, 4'b0001, 0, 2, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0000, 0, 2, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0001, 0, 2, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'd2);
      // MODE 3: toggle
      v(1, 1, 4'b0001, 4'b0001, 0, 3, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0001, 0, 3, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'd2);
      v(0, 1, 4'b0001, 4'b0001, 0, 3, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'd3);
      // MODE 4: last-wins
      v(1, 1, 4'b0001, 4'b0000, 0, 4, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'd0);
      v(0, 1, 4'b0001, 4'b0001, 0, 4, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'd1);
      v(0, 1, 4'b0000, 4'b0000, 0, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0000, 4'b0001, 0, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0001, 0, 4, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'd2);
      v(0, 1, 4'b0000, 4'b0000, 0, 4, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'd2);
      v(0, 1, 4'b0001, 4'b0001, 0, 4, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'd3);
      v(0, 1, 4'b0001, 4'b0001, 0, 4, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'd4);
      // undefined MODE behaves as hold
      v(1, 1, 4'b0001, 4'b0001, 0, 7, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0000, 0, 7, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'd1);
      v(0, 1, 4'b0001, 4'b0001, 0, 7, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 8'd2);
      // enable gating
      v(1, 0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      v(0, 0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      v(0, 0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      v(0, 1, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'd0);
      v(0, 0, 4'b0000, 4'b0001, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      v(0, 0, 4'b0010, 4'b0010, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      v(0, 1, 4'b0000, 4'b0000, 0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      // 2-bit counter: one count per cycle, saturation, clear, clear+conflict
      v(1, 1, 4'b0011, 4'b0011, 0, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 8'd1);
      v(0, 1, 4'b0011, 4'b0011, 0, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 8'd2);
      v(0, 1, 4'b0011, 4'b0011, 0, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 8'd3);
      v(0, 1, 4'b0011, 4'b0011, 0, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 8'd3);
      v(0, 1, 4'b0011, 4'b0011, 0, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 8'd3);
      v(0, 1, 4'b0000, 4'b0000, 1, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      v(0, 1, 4'b1000, 4'b1000, 1, 5, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 8'd1);
      v(0, 0, 4'b0000, 4'b0000, 1, 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);

      @(posedge clk);
      #1;
      chk("init", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      chk("init", 6, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) rst_pulse();
         step(vecs[i].en, vecs[i].s, vecs[i].r, vecs[i].clr);
         chk($sformatf("vec%0d", i), vecs[i].dut, vecs[i].q, vecs[i].rise,
             vecs[i].fall, vecs[i].conf, vecs[i].cnt);
      end

      // asynchronous reset between edges, conflict under reset discarded
      rst_pulse();
      step(1, 4'b0011, 4'b0011, 0);
      step(1, 4'b0101, 4'b0000, 0);
      chk("pre_rst", 0, 4'b0101, 4'b0101, 4'b0000, 4'b0011, 8'd1);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      t_en = 1'b1;
      t_s  = 4'b1111;
      t_r  = 4'b1111;
      @(posedge clk);
      #1;
      chk("held_rst", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      reset = 1'b0;
      step(1, 4'b0000, 4'b0000, 0);
      chk("post_rst", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      step(1, 4'b0001, 4'b0000, 0);
      chk("first_upd", 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'd0);

      // RESET_Q=1 instance, reset in the middle of activity
      rst_pulse();
      chk("rq1_rst", 6, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      step(1, 4'b0001, 4'b0001, 0);
      chk("rq1_conf", 6, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 8'd1);
      step(1, 4'b0000, 4'b1101, 0);
      chk("rq1_clr", 6, 4'b0010, 4'b0000, 4'b1101, 4'b0001, 8'd1);
      #3;
      reset = 1'b1;
      #1;
      chk("rq1_async", 6, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
